buf_exchange_hub: RTL and testbench

- Shared hub at the multicore top level. It sits at the far end of each core's buffer-register interface.
- Collects each core's published pair (buf_val_1/buf_val_2) when that core raises buf_flag. Runs a barrier across all active cores, then commits the pairs to a double-buffered table.
- Serves each core's two buffer-address lookups from that table and drives the common all_buf_flags release.

---
 rtl/buf_exchange_hub.sv | 93 +++++++++
 tb/tb_buf_exchange_hub.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/buf_exchange_hub.sv
// rtl/buf_exchange_hub.sv - multicore barrier hub with a double-buffered value exchange table
module buf_exchange_hub #(
    parameter int               CORES       = 4,
    parameter logic [CORES-1:0] ACTIVE_MASK = {CORES{1'b1}}
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [32*CORES-1:0] core_buf_val_1,
    input  logic [32*CORES-1:0] core_buf_val_2,
    input  logic [CORES-1:0]    core_buf_flag,
    input  logic [5*CORES-1:0]  core_addr_1,
    input  logic [5*CORES-1:0]  core_addr_2,
    output logic [32*CORES-1:0] core_select_1,
    output logic [32*CORES-1:0] core_select_2,
    output logic                all_buf_flags,
    output logic [CORES-1:0]    arrived,
    output logic [7:0]          epoch
);

    typedef enum logic {COLLECT, RELEASE} state_t;

    state_t                 state, state_next;
    logic [CORES-1:0][31:0] shadow_1, shadow_2;
    logic [CORES-1:0][31:0] commit_1, commit_2;
    logic [CORES-1:0][31:0] merged_1, merged_2;
    logic [CORES-1:0]       new_arr;
    logic                   fire;
    logic                   leave;

    always_comb begin
        state_next = state;
        new_arr    = '0;
        fire       = 1'b0;
        leave      = 1'b0;
        merged_1   = shadow_1;
        merged_2   = shadow_2;
        case (state)
            COLLECT: begin
                new_arr = core_buf_flag & ~arrived & ACTIVE_MASK;
                fire    = &(arrived | new_arr | ~ACTIVE_MASK);
                if (fire) state_next = RELEASE;
            end
            RELEASE: begin
                leave = (core_buf_flag & ACTIVE_MASK) == '0;
                if (leave) state_next = COLLECT;
            end
        endcase
        // the commit on the firing edge must include the captures made on that same edge
        for (int i = 0; i < CORES; i++) begin
            if (new_arr[i]) begin
                merged_1[i] = core_buf_val_1[32*i +: 32];
                merged_2[i] = core_buf_val_2[32*i +: 32];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= COLLECT;
            arrived  <= '0;
            epoch    <= '0;
            shadow_1 <= '0;
            shadow_2 <= '0;
            commit_1 <= '0;
            commit_2 <= '0;
        end else begin
            state    <= state_next;
            shadow_1 <= merged_1;
            shadow_2 <= merged_2;
            arrived  <= leave ? '0 : (arrived | new_arr);
            if (fire) begin
                commit_1 <= merged_1;
                commit_2 <= merged_2;
                epoch    <= epoch + 8'd1;
            end
        end
    end

    assign all_buf_flags = (state == RELEASE);

    // out-of-range addresses match no entry and read as zero
    always_comb begin
        core_select_1 = '0;
        core_select_2 = '0;
        for (int c = 0; c < CORES; c++) begin
            for (int j = 0; j < CORES; j++) begin
                if (core_addr_1[5*c +: 5] == 5'(j)) core_select_1[32*c +: 32] = commit_1[j];
                if (core_addr_2[5*c +: 5] == 5'(j)) core_select_2[32*c +: 32] = commit_2[j];
            end
        end
    end

endmodule

// File: tb/tb_buf_exchange_hub.sv
// tb/tb_buf_exchange_hub.sv - scoreboard bench for buf_exchange_hub (full mask and mask 0101)
module tb_buf_exchange_hub;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic [127:0] v1 = '0, v2 = '0;
    logic [3:0]   flag = '0;
    logic [19:0]  a1 = '0, a2 = '0;

    logic [127:0] sel1_a, sel2_a, sel1_b, sel2_b;
    logic         abf_a, abf_b;
    logic [3:0]   arr_a, arr_b;
    logic [7:0]   ep_a, ep_b;

    logic [127:0] nv1 = '0, nv2 = '0;
    logic [3:0]   nf = '0;
    logic [19:0]  na1 = '0, na2 = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    buf_exchange_hub #(.CORES(4)) dut_a (
        .Clk(Clk), .Reset(Reset),
        .core_buf_val_1(v1), .core_buf_val_2(v2), .core_buf_flag(flag),
        .core_addr_1(a1), .core_addr_2(a2),
        .core_select_1(sel1_a), .core_select_2(sel2_a),
        .all_buf_flags(abf_a), .arrived(arr_a), .epoch(ep_a)
    );

    buf_exchange_hub #(.CORES(4), .ACTIVE_MASK(4'b0101)) dut_b (
        .Clk(Clk), .Reset(Reset),
        .core_buf_val_1(v1), .core_buf_val_2(v2), .core_buf_flag(flag),
        .core_addr_1(a1), .core_addr_2(a2),
        .core_select_1(sel1_b), .core_select_2(sel2_b),
        .all_buf_flags(abf_b), .arrived(arr_b), .epoch(ep_b)
    );

    // reference model: one entry per instance, updated once per clock edge
    logic [3:0]  mask  [2];
    logic [31:0] sh1 [2][4];
    logic [31:0] sh2 [2][4];
    logic [31:0] cm1 [2][4];
    logic [31:0] cm2 [2][4];
    logic [3:0]  m_arr [2];
    logic        m_rel [2];
    logic [7:0]  m_ep  [2];

    typedef struct packed {
        logic [1:0][3:0]   arr;
        logic [1:0]        rel;
        logic [1:0][7:0]   ep;
        logic [1:0][127:0] s1;
        logic [1:0][127:0] s2;
    } exp_t;

    exp_t q[$];

    function automatic void check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
        end
    endfunction

    task automatic model_edge(input int k, input logic rst);
        if (!rst) begin
            m_arr[k] = '0;
            m_rel[k] = 1'b0;
            m_ep[k]  = '0;
            for (int i = 0; i < 4; i++) begin
                sh1[k][i] = '0; sh2[k][i] = '0; cm1[k][i] = '0; cm2[k][i] = '0;
            end
        end else if (!m_rel[k]) begin
            for (int i = 0; i < 4; i++) begin
                if (flag[i] && !m_arr[k][i] && mask[k][i]) begin
                    sh1[k][i]   = v1[32*i +: 32];
                    sh2[k][i]   = v2[32*i +: 32];
                    m_arr[k][i] = 1'b1;
                end
            end
            if ((m_arr[k] | ~mask[k]) == 4'hF) begin
                for (int i = 0; i < 4; i++) begin
                    cm1[k][i] = sh1[k][i];
                    cm2[k][i] = sh2[k][i];
                end
                m_rel[k] = 1'b1;
                m_ep[k]  = m_ep[k] + 8'd1;
            end
        end else if ((flag & mask[k]) == 4'h0) begin
            m_rel[k] = 1'b0;
            m_arr[k] = '0;
        end
    endtask

    task automatic step(input logic rst);
        exp_t        e;
        logic [4:0]  ad;
        @(negedge Clk);
        Reset = rst;
        flag  = nf;
        v1    = nv1;
        v2    = nv2;
        a1    = na1;
        a2    = na2;
        for (int k = 0; k < 2; k++) begin
            model_edge(k, rst);
            e.arr[k] = m_arr[k];
            e.rel[k] = m_rel[k];
            e.ep[k]  = m_ep[k];
            for (int c = 0; c < 4; c++) begin
                ad = a1[5*c +: 5];
                e.s1[k][32*c +: 32] = (ad < 5'd4) ? cm1[k][ad[1:0]] : 32'h0;
                ad = a2[5*c +: 5];
                e.s2[k][32*c +: 32] = (ad < 5'd4) ? cm2[k][ad[1:0]] : 32'h0;
            end
        end
        q.push_back(e);
    endtask

    // monitor: samples after each rising edge and compares against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("arrived_a", 128'(arr_a), 128'(e.arr[0]));
                check("arrived_b", 128'(arr_b), 128'(e.arr[1]));
                check("all_buf_flags_a", 128'(abf_a), 128'(e.rel[0]));
                check("all_buf_flags_b", 128'(abf_b), 128'(e.rel[1]));
                check("epoch_a", 128'(ep_a), 128'(e.ep[0]));
                check("epoch_b", 128'(ep_b), 128'(e.ep[1]));
                check("select_1_a", sel1_a, e.s1[0]);
                check("select_2_a", sel2_a, e.s2[0]);
                check("select_1_b", sel1_b, e.s1[1]);
                check("select_2_b", sel2_b, e.s2[1]);
            end
        end
    end

    initial begin
        mask[0] = 4'hF;
        mask[1] = 4'h5;
        for (int k = 0; k < 2; k++) model_edge(k, 1'b0);

        // reset, then staggered arrivals on cycles 2,4,5,7
        na1 = {5'd3, 5'd2, 5'd1, 5'd0};
        na2 = {5'd3, 5'd2, 5'd1, 5'd0};
        for (int i = 0; i < 4; i++) begin
            nv1[32*i +: 32] = 32'h10 + 32'(i);
            nv2[32*i +: 32] = 32'h20 + 32'(i);
        end
        step(1'b0);
        step(1'b0);
        for (int cyc = 0; cyc < 10; cyc++) begin
            nf[0] = (cyc >= 2);
            nf[1] = (cyc >= 4);
            nf[2] = (cyc >= 5);
            nf[3] = (cyc >= 7);
            if (cyc == 8) begin
                na1[14:10] = 5'd3;
                na2[4:0]   = 5'd1;
            end
            step(1'b1);
        end
        nf = 4'h0;
        step(1'b1);
        step(1'b1);

        // simultaneous arrivals, then changes during release, then a re-flag
        nv1[31:0]  = 32'hAA;
        nv1[63:32] = 32'hBB;
        na1 = {5'd7, 5'd1, 5'd1, 5'd0};
        nf = 4'b0011; step(1'b1); step(1'b1);
        nf = 4'b1111; step(1'b1); step(1'b1); step(1'b1);
        nv1[31:0] = 32'hDEAD; step(1'b1); step(1'b1);
        nf = 4'b0000; step(1'b1);
        nf = 4'b0001; step(1'b1); step(1'b1); step(1'b1);

        // reset in the middle of a collection
        nf = 4'b0011; step(1'b1); step(1'b1);
        nf = 4'b0000; step(1'b0); step(1'b0);
        step(1'b1);

        // randomized cooperative cores
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (m_rel[0]) begin
                    if (nf[i] && $urandom_range(0, 1) == 0) nf[i] = 1'b0;
                end else if (!nf[i]) begin
                    if ($urandom_range(0, 9) < 3) begin
                        nf[i] = 1'b1;
                        nv1[32*i +: 32] = $urandom;
                        nv2[32*i +: 32] = $urandom;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    nf[i] = 1'b0;
                end
                if ($urandom_range(0, 9) == 0) begin
                    nv1[32*i +: 32] = $urandom;
                    nv2[32*i +: 32] = $urandom;
                end
                na1[5*i +: 5] = 5'($urandom_range(0, 7));
                na2[5*i +: 5] = 5'($urandom_range(0, 7));
            end
            step($urandom_range(0, 499) != 0);
        end

        // 256 back-to-back barriers from a fresh reset: epoch wraps to zero
        nf = 4'h0;
        step(1'b0);
        for (int n = 0; n < 256; n++) begin
            for (int i = 0; i < 4; i++) nv1[32*i +: 32] = $urandom;
            nf = 4'hF; step(1'b1);
            nf = 4'h0; step(1'b1);
        end
        step(1'b1);

        @(negedge Clk);
        @(negedge Clk);
        check("scoreboard_drained", 128'(q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
